usb_tx_packetizer: RTL



---
 rtl/usb_pkg.sv | 43 ++++
 rtl/usb_tx_packetizer_if.sv | 44 ++++
 rtl/usb_tx_crc16.sv | 36 +++
 rtl/usb_tx_packetizer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB transmit definitions.
//   - PID nibbles for the handshake and data packets this block sends.
//   - Transmit FSM state enum.
//   - CRC16 seed and polynomial, and the default SYNC byte.
//   - Line encodings for {dp,dm}.
//   - One serial CRC16 step function.
package usb_pkg;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // {dp,dm} line encodings
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    PID  = 3'd2,
    DATA = 3'd3,
    CRC  = 3'd4,
    EOP  = 3'd5
  } tx_state_t;

  // One serial CRC16 step.  The feedback bit is the incoming bit XOR the
  // register MSB, and the register shifts toward the MSB.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        bit_in,
                                             input logic [15:0] poly);
    logic fb;
    fb = bit_in ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_tx_packetizer_if.sv
// Request/line bundle of usb_tx_packetizer.
//   master : packet requester (drives start/pid/has_data/data, reads line)
//   slave  : the packetizer
// Signals:
//   start, pid[3:0], has_data, data[DATA_BITS-1:0]  request, latched at accept
//   corrupt_crc                                     request (only with USB_TX_CRC_CORRUPT_EN)
//   dp, dm                                          USB line pair
//   busy, done                                      packet status
//   dbg_state                                       current transmit FSM state
// Handshake: a request is accepted on any rising clk edge where start=1 and
// busy=0; the request fields are captured on that same edge. start seen
// while busy=1 is dropped. done pulses for one cycle after the packet ends.
interface usb_tx_packetizer_if
  import usb_pkg::*;
#(
  parameter int DATA_BITS = 64
);

  logic                 start;
  logic [3:0]           pid;
  logic                 has_data;
  logic [DATA_BITS-1:0] data;
`ifdef USB_TX_CRC_CORRUPT_EN
  logic                 corrupt_crc;
`endif
  logic                 dp;
  logic                 dm;
  logic                 busy;
  logic                 done;
  tx_state_t            dbg_state;

`ifdef USB_TX_CRC_CORRUPT_EN
  modport master (output start, pid, has_data, data, corrupt_crc,
                  input  dp, dm, busy, done, dbg_state);
  modport slave  (input  start, pid, has_data, data, corrupt_crc,
                  output dp, dm, busy, done, dbg_state);
`else
  modport master (output start, pid, has_data, data,
                  input  dp, dm, busy, done, dbg_state);
  modport slave  (input  start, pid, has_data, data,
                  output dp, dm, busy, done, dbg_state);
`endif

endinterface

// File: rtl/usb_tx_crc16.sv
// Serial CRC16 register for the transmit payload.
// Ports:
//   clk, rst_l  clock, asynchronous active-low reset (reset loads CRC_INIT)
//   clear       reload CRC_INIT (wins over enable)
//   enable      advance by one payload bit
//   bit_in      payload bit
//   crc[15:0]   current register value (uncomplemented)
module usb_tx_crc16
  import usb_pkg::*;
#(
  parameter logic [15:0] INIT = 16'hFFFF,
  parameter logic [15:0] POLY = 16'h8005
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_crc <= INIT;
    end else if (clear) begin
      r_crc <= INIT;
    end else if (enable) begin
      r_crc <= crc16_step(r_crc, bit_in, POLY);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB transmit packetizer: SYNC, PID, optional payload + CRC16, EOP, with
// bit stuffing and NRZI encoding onto dp/dm.
// Ports:
//   clk, rst_l  clock, asynchronous active-low reset
//   bus         usb_tx_packetizer_if.slave (start/pid/has_data/data in,
//               dp/dm/busy/done/dbg_state out)
// Build option: USB_TX_CRC_CORRUPT_EN adds bus.corrupt_crc; when it is latched
// high, bit 0 of the transmitted CRC field is inverted.
//
// Timing: the line value of a cycle is decoded combinationally from the
// current state and bit index, so the first SYNC bit is on the line in the
// cycle right after accept and reset forces J immediately.
module usb_tx_packetizer
  import usb_pkg::*;
#(
  parameter int          DATA_BITS    = 64,
  parameter logic [7:0]  SYNC_PATTERN = 8'h80,
  parameter logic [15:0] CRC_INIT     = 16'hFFFF,
  parameter logic [15:0] CRC_POLY     = 16'h8005
) (
  input logic               clk,
  input logic               rst_l,
  usb_tx_packetizer_if.slave bus
);

  // Index must cover DATA_BITS-1 and the 16 CRC bits.
  localparam int IDX_W = ($clog2(DATA_BITS) > 4) ? $clog2(DATA_BITS) : 4;

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [3:0]           r_pid;
  logic                 r_has_data;
  logic [DATA_BITS-1:0] r_data;
  logic [2:0]           r_stuff_cnt;
  logic                 r_lvl;
  logic                 r_done;
  logic                 r_corrupt;

  logic                 w_accept;
  logic                 w_stuff;
  logic                 w_encoded;
  logic                 w_raw_bit;
  logic                 w_line_bit;
  logic                 w_lvl;
  logic                 w_done_nxt;
  logic [1:0]           w_line;
  logic [7:0]           w_pid_byte;
  logic [15:0]          w_crc;
  logic                 w_crc_bit;
  logic                 w_crc_en;

  assign w_accept   = (r_state == IDLE) && bus.start;
  // Six line 1s in a row: the next line cycle is a stuffed 0 and the
  // bit position is held. Also applies in EOP so a run completed by the
  // last CRC bit gets its stuffed 0 before the SE0s.
  assign w_stuff    = (r_stuff_cnt == 3'd6) && (r_state != IDLE);
  assign w_pid_byte = {~r_pid, r_pid};

  assign w_crc_bit = ~w_crc[4'd15 - r_idx[3:0]]
                   ^ (r_corrupt && (r_idx[3:0] == 4'd15));

  assign w_crc_en = (r_state == DATA) && !w_stuff;

  usb_tx_crc16 #(
    .INIT (CRC_INIT),
    .POLY (CRC_POLY)
  ) u_crc (
    .clk    (clk),
    .rst_l  (rst_l),
    .clear  (w_accept),
    .enable (w_crc_en),
    .bit_in (r_data[0]),
    .crc    (w_crc)
  );

  // Next-state, raw bit and line decode
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_raw_bit   = 1'b1;
    w_encoded   = 1'b0;
    w_done_nxt  = 1'b0;
    w_line      = LINE_J;
    w_line_bit  = 1'b1;
    w_lvl       = r_lvl;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = SYNC;
          w_idx_nxt   = '0;
        end
      end
      SYNC: begin
        w_encoded = 1'b1;
        w_raw_bit = SYNC_PATTERN[r_idx[2:0]];
        if (!w_stuff) begin
          if (r_idx == IDX_W'(7)) begin
            w_state_nxt = PID;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      PID: begin
        w_encoded = 1'b1;
        w_raw_bit = w_pid_byte[r_idx[2:0]];
        if (!w_stuff) begin
          if (r_idx == IDX_W'(7)) begin
            w_state_nxt = r_has_data ? DATA : EOP;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      DATA: begin
        w_encoded = 1'b1;
        w_raw_bit = r_data[0];
        if (!w_stuff) begin
          if (r_idx == IDX_W'(DATA_BITS - 1)) begin
            w_state_nxt = CRC;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      CRC: begin
        w_encoded = 1'b1;
        w_raw_bit = w_crc_bit;
        if (!w_stuff) begin
          if (r_idx == IDX_W'(15)) begin
            w_state_nxt = EOP;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      EOP: begin
        if (w_stuff) begin
          w_encoded = 1'b1;
        end else begin
          w_line = (r_idx < IDX_W'(2)) ? LINE_SE0 : LINE_J;
          if (r_idx == IDX_W'(2)) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    // NRZI: a 0 toggles the level, a 1 holds it
    w_line_bit = w_raw_bit & ~w_stuff;
    w_lvl      = w_line_bit ? r_lvl : ~r_lvl;
    if (w_encoded) begin
      w_line = {w_lvl, ~w_lvl};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_pid       <= '0;
      r_has_data  <= 1'b0;
      r_data      <= '0;
      r_stuff_cnt <= 3'd0;
      r_lvl       <= 1'b1;
      r_done      <= 1'b0;
      r_corrupt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;

      if (w_accept) begin
        r_pid      <= bus.pid;
        r_has_data <= bus.has_data;
        r_data     <= bus.data;
`ifdef USB_TX_CRC_CORRUPT_EN
        r_corrupt  <= bus.corrupt_crc;
`else
        r_corrupt  <= 1'b0;
`endif
      end else if ((r_state == DATA) && !w_stuff) begin
        r_data <= r_data >> 1;
      end

      // Counts line 1s; stuffed zeros clear it like any other 0.
      if (w_encoded) begin
        r_stuff_cnt <= w_line_bit ? (r_stuff_cnt + 3'd1) : 3'd0;
      end else begin
        r_stuff_cnt <= 3'd0;
      end

      // Level is only meaningful while encoding; outside that it rests at J.
      r_lvl <= w_encoded ? w_lvl : 1'b1;
    end
  end

  assign bus.dp        = w_line[1];
  assign bus.dm        = w_line[0];
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule
